// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin slice arbiter.
// Optional feature macro: ARB_LOCK_EN (adds the lock port to rr_slice_arbiter).
package arb_pkg;

  // Arbiter control states: nobody owns the port, or one master owns it.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Helpers work on a fixed 32-bit container; N is bounded to this width.
  localparam int unsigned ARB_MAX_N = 32;

  // Rotate the low n bits of v right by sh (bit sh moves to bit 0).
  function automatic logic [31:0] rotr(input logic [31:0] v,
                                       input logic [31:0] sh,
                                       input logic [31:0] n);
    logic [31:0] r;
    logic [4:0]  p;
    r = 32'b0;
    for (int i = 0; i < 32; i++) begin
      p = 5'd0;
      if (32'(i) < n) begin
        p    = 5'((32'(i) + sh) % n);
        r[i] = v[p];
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  // Rotate the low n bits of v left by sh (bit 0 moves to bit sh).
  function automatic logic [31:0] rotl(input logic [31:0] v,
                                       input logic [31:0] sh,
                                       input logic [31:0] n);
    logic [31:0] r;
    logic [4:0]  p;
    r = 32'b0;
    for (int i = 0; i < 32; i++) begin
      p = 5'd0;
      if (32'(i) < n) begin
        p    = 5'((32'(i) + sh) % n);
        r[p] = v[i];
      end
    end
    return r;
  endfunction

  // Encode a one-hot vector into its bit index (0 for an all-zero vector).
  function automatic logic [31:0] onehot2idx(input logic [31:0] oh);
    logic [31:0] idx;
    idx = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) begin
        idx = idx | 32'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: finds the first set request at or
// after start_i, wrapping past N-1 back to 0.
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [N-1:0]     pick_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [31:0] req_ext_s;
  logic [31:0] start_ext_s;
  logic [31:0] rot_s;
  logic [31:0] low_s;
  logic [31:0] pick_ext_s;
  logic [31:0] idx_ext_s;
  logic        unused_s;

  // Rotate start to bit 0, isolate the lowest set bit, rotate it back.
  always_comb begin
    req_ext_s            = 32'b0;
    req_ext_s[N-1:0]     = req_i;
    start_ext_s          = 32'b0;
    start_ext_s[IDX_W-1:0] = start_i;
    rot_s      = rotr(req_ext_s, start_ext_s, 32'(N));
    low_s      = rot_s & (~rot_s + 32'd1);
    pick_ext_s = rotl(low_s, start_ext_s, 32'(N));
    idx_ext_s  = onehot2idx(pick_ext_s);
  end

  assign found_o  = |req_i;
  assign pick_o   = pick_ext_s[N-1:0];
  assign idx_o    = idx_ext_s[IDX_W-1:0];
  // Upper container bits are always zero; fold them away explicitly.
  assign unused_s = ^{pick_ext_s, idx_ext_s};

endmodule

// File: rtl/rr_slice_arbiter.sv
// N-way round-robin arbiter with a bounded time slice per grant.
// Registered one-hot grant plus encoded index; zero dead cycles on handover.
// Optional feature macro: ARB_LOCK_EN (lock input lets the owner extend past its slice).
module rr_slice_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned N     = 4,
  parameter  int unsigned SLICE = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]     lock,
`endif
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  localparam int unsigned      CNT_W    = $clog2(SLICE + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLICE);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  if (N < 2 || N > ARB_MAX_N) begin : g_bad_n
    $error("rr_slice_arbiter: N must be in 2..32");
  end
  if (SLICE < 1) begin : g_bad_slice
    $error("rr_slice_arbiter: SLICE must be >= 1");
  end

  arb_state_t       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     gnt_q;
  logic             gnt_valid_q;
  logic [IDX_W-1:0] gnt_idx_q;

  logic [IDX_W-1:0] start_s;
  logic [IDX_W-1:0] nxt_ptr_s;
  logic             found_s;
  logic [N-1:0]     pick_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             owner_req_s;
  logic             expired_s;
  logic             hold_s;
  logic             release_s;

  // Search start: saved pointer when idle, the slot after the owner when granting.
  always_comb begin
    if (state_q == GRANT) begin
      if (gnt_idx_q == IDX_LAST) begin
        start_s = {IDX_W{1'b0}};
      end else begin
        start_s = gnt_idx_q + IDX_ONE;
      end
    end else begin
      start_s = ptr_q;
    end
  end

  rr_priority_pick #(.N(N)) u_pick (
    .req_i   (req),
    .start_i (start_s),
    .found_o (found_s),
    .pick_o  (pick_s),
    .idx_o   (pick_idx_s)
  );

  // Pointer after a new grant: the slot following the new owner, wrapping.
  always_comb begin
    if (pick_idx_s == IDX_LAST) begin
      nxt_ptr_s = {IDX_W{1'b0}};
    end else begin
      nxt_ptr_s = pick_idx_s + IDX_ONE;
    end
  end

  // Release decision: owner dropped its request, or its slice is used up and not locked.
  always_comb begin
    owner_req_s = |(req & gnt_q);
    expired_s   = (cnt_q == CNT_MAX);
`ifdef ARB_LOCK_EN
    hold_s      = |(req & lock & gnt_q);
`else
    hold_s      = 1'b0;
`endif
    release_s   = !owner_req_s || (expired_s && !hold_s);
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= {IDX_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      gnt_q       <= {N{1'b0}};
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= {IDX_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (found_s) begin
            state_q     <= GRANT;
            gnt_q       <= pick_s;
            gnt_valid_q <= 1'b1;
            gnt_idx_q   <= pick_idx_s;
            cnt_q       <= CNT_ONE;
            ptr_q       <= nxt_ptr_s;
          end
        end
        GRANT: begin
          if (release_s) begin
            if (found_s) begin
              // Hand over in the same edge; may re-grant the same owner.
              gnt_q       <= pick_s;
              gnt_valid_q <= 1'b1;
              gnt_idx_q   <= pick_idx_s;
              cnt_q       <= CNT_ONE;
              ptr_q       <= nxt_ptr_s;
            end else begin
              state_q     <= IDLE;
              gnt_q       <= {N{1'b0}};
              gnt_valid_q <= 1'b0;
              gnt_idx_q   <= {IDX_W{1'b0}};
              cnt_q       <= {CNT_W{1'b0}};
              ptr_q       <= start_s;
            end
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q     <= IDLE;
          gnt_q       <= {N{1'b0}};
          gnt_valid_q <= 1'b0;
          gnt_idx_q   <= {IDX_W{1'b0}};
          cnt_q       <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_rr_slice_arbiter.sv
// Self-checking bench: two arbiters (SLICE=4 and SLICE=1) share one request
// stream and are compared every cycle against a behavioural model.
module tb_rr_slice_arbiter;

  localparam int N = 4;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] lock;
  logic [N-1:0] gnt_a, gnt_b;
  logic         valid_a, valid_b;
  logic [1:0]   idx_a, idx_b;

  int total = 0;
  int bad   = 0;

  // Model state per instance: owner (-1 = none), cycles held, next search start.
  int m_owner [2];
  int m_cnt   [2];
  int m_ptr   [2];
  int m_slice [2] = '{4, 1};

  always #5 clk = ~clk;

  rr_slice_arbiter #(.N(4), .SLICE(4)) dut_a (
    .clk(clk), .reset(reset), .req(req),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt_a), .gnt_valid(valid_a), .gnt_idx(idx_a)
  );

  rr_slice_arbiter #(.N(4), .SLICE(1)) dut_b (
    .clk(clk), .reset(reset), .req(req),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt_b), .gnt_valid(valid_b), .gnt_idx(idx_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1;
      m_cnt[i]   = 0;
      m_ptr[i]   = 0;
    end
  endtask

  // First requesting master scanning from 'from', wrapping; -1 if none.
  function automatic int first_req(input int from);
    int j;
    first_req = -1;
    for (int off = 0; off < N; off++) begin
      j = (from + off) % N;
      if (first_req < 0 && req[j]) first_req = j;
    end
  endfunction

  task automatic model_step(input int i);
    int  k, j;
    bit  rel;
    if (m_owner[i] < 0) begin
      j = first_req(m_ptr[i]);
      if (j >= 0) begin
        m_owner[i] = j; m_cnt[i] = 1; m_ptr[i] = (j + 1) % N;
      end
    end else begin
      k   = m_owner[i];
      rel = !req[k] || (m_cnt[i] >= m_slice[i] && !(LOCK_EN && lock[k]));
      if (rel) begin
        j = first_req((k + 1) % N);
        if (j >= 0) begin
          m_owner[i] = j; m_cnt[i] = 1; m_ptr[i] = (j + 1) % N;
        end else begin
          m_owner[i] = -1; m_cnt[i] = 0; m_ptr[i] = (k + 1) % N;
        end
      end else if (m_cnt[i] < m_slice[i]) begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  function automatic logic [31:0] exp_gnt(input int i);
    return (m_owner[i] < 0) ? 32'd0 : (32'd1 << m_owner[i]);
  endfunction

  function automatic logic [31:0] exp_idx(input int i);
    return (m_owner[i] < 0) ? 32'd0 : 32'(m_owner[i]);
  endfunction

  task automatic check_all();
    check("gnt_a",   {28'b0, gnt_a},   exp_gnt(0));
    check("valid_a", {31'b0, valid_a}, {31'b0, m_owner[0] >= 0});
    check("idx_a",   {30'b0, idx_a},   exp_idx(0));
    check("gnt_b",   {28'b0, gnt_b},   exp_gnt(1));
    check("valid_b", {31'b0, valid_b}, {31'b0, m_owner[1] >= 0});
    check("idx_b",   {30'b0, idx_b},   exp_idx(1));
  endtask

  // Drive inputs, advance one edge, update the model, sample 1 time unit later.
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l);
    req  = r;
    lock = l;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  // Assert reset between edges: outputs must clear before any further edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 check_all();
    #2 reset = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r, l;
    // Reset with all masters requesting.
    reset = 1'b0;
    req   = 4'b1111;
    lock  = 4'b0000;
    model_reset();
    #1 check_all();
    @(posedge clk); #1 check_all();
    @(posedge clk); #1 check_all();
    #2 reset = 1'b1;
    cycle(4'b1111, 4'b0000);
    check("first_grant", {28'b0, gnt_a}, 32'h1);

    // Slice rotation with everyone requesting.
    for (int c = 0; c < 20; c++) cycle(4'b1111, 4'b0000);

    // Early drop of the owner hands over at the same edge.
    do_reset();
    cycle(4'b0010, 4'b0000);
    cycle(4'b0010, 4'b0000);
    cycle(4'b1001, 4'b0000);
    check("early_drop_idx", {30'b0, idx_a}, 32'd3);

    // Single requester: continuous grant, then pointer wrap after idle.
    do_reset();
    for (int c = 0; c < 9; c++) cycle(4'b0100, 4'b0000);
    cycle(4'b0000, 4'b0000);
    cycle(4'b0101, 4'b0000);
    check("wrap_gnt", {28'b0, gnt_a}, 32'h1);

    // Reset mid-grant, then restart from pointer 0.
    cycle(4'b1111, 4'b0000);
    cycle(4'b1111, 4'b0000);
    do_reset();
    cycle(4'b1111, 4'b0000);

`ifdef ARB_LOCK_EN
    // Locked owner keeps the grant past its slice.
    do_reset();
    for (int c = 0; c < 10; c++) cycle(4'b0011, 4'b0001);
    check("lock_hold", {28'b0, gnt_a}, 32'h1);
    cycle(4'b0011, 4'b0000);
    check("lock_release", {28'b0, gnt_a}, 32'h2);
`endif

    // Randomised traffic with sticky requests and occasional resets.
    r = 4'b0000;
    l = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) l = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) do_reset();
      cycle(r, l);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
